// File: rtl/arb_pkg.sv
// Shared definitions for the rotating priority arbiter: FSM encoding, widths
// and a one-hot helper for building grant vectors.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin winner pick: rotate the request vector so the
// current priority pointer sits at bit 0, then take the lowest set bit.
module arb_rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               any,
    output logic [ID_W-1:0]    winner
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [ID_W-1:0]      offset;

    always_comb begin
        req_dbl = {req, req} >> ptr;
        rot     = req_dbl[NUM_REQ-1:0];
        any     = 1'b1;
        offset  = '0;
        casez (rot)
            4'b???1: offset = 2'd0;
            4'b??10: offset = 2'd1;
            4'b?100: offset = 2'd2;
            4'b1000: offset = 2'd3;
            default: any    = 1'b0;
        endcase
        // Offset is relative to ptr; the 2-bit add wraps 3 -> 0 for free.
        winner = offset + ptr;
    end

endmodule

// File: rtl/rotating_priority_arbiter.sv
// Round-robin arbiter for one shared resource: grants a requester, holds the
// grant until done / request drop / MAX_HOLD overrun, then rotates priority.
module rotating_priority_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id,
    output logic               timeout
);

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [7:0]         hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic               timeout_q, timeout_d;

    logic               pick_any;
    logic [ID_W-1:0]    pick_winner;
    logic               release_now;

    arb_rr_pick u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_winner)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        timeout_d   = 1'b0;
        release_now = done || !req[gnt_id_q] || (hold_cnt_q == HOLD_LIM);

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_d       = onehot4(pick_winner);
                    gnt_id_d    = pick_winner;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (hold_cnt_q != HOLD_LIM) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
                if (release_now) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gnt_id_d    = '0;
                    hold_cnt_d  = '0;
                    ptr_d       = gnt_id_q + 2'd1;
                    state_d     = ST_IDLE;
                    // Only a pure overrun counts: done or a dropped request take precedence.
                    timeout_d   = !done && req[gnt_id_q];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rotating_priority_arbiter.sv
// Directed bench for the rotating priority arbiter: a per-cycle vector table
// plus hand-written timeout, reset-mid-grant and request-drop sequences.
module tb_rotating_priority_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       timeout;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] exp_gnt;
        logic       exp_tmo;
    } vec_t;

    vec_t vecs[$];

    rotating_priority_arbiter #(.MAX_HOLD(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [1:0] id_of(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic void add(input logic r, input logic [3:0] rq, input logic d,
                                input logic [3:0] eg, input logic et);
        vec_t v;
        v.rst = r; v.req = rq; v.done = d; v.exp_gnt = eg; v.exp_tmo = et;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs, let the edge happen, then check all outputs.
    task automatic step(input logic r, input logic [3:0] rq, input logic d,
                        input logic [3:0] eg, input logic et, input string name);
        logic [7:0] act;
        logic [7:0] exp;
        reset = r;
        req   = rq;
        done  = d;
        @(posedge clk);
        #1;
        act = {gnt, gnt_valid, gnt_id, timeout};
        exp = {eg, |eg, id_of(eg), et};
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got gnt=%b valid=%b id=%0d tmo=%b, want gnt=%b valid=%b id=%0d tmo=%b",
                     name, gnt, gnt_valid, gnt_id, timeout, eg, |eg, id_of(eg), et);
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        done  = 1'b0;

        // Reset held with all requests high, then first grant goes to 0.
        add(1, 4'b1111, 0, 4'b0000, 0);
        add(1, 4'b1111, 0, 4'b0000, 0);
        add(1, 4'b1111, 0, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b0001, 0);
        // Rotation 0,1,2,3,0 with one idle cycle between owners.
        add(0, 4'b1111, 1, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b0010, 0);
        add(0, 4'b1111, 1, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b0100, 0);
        add(0, 4'b1111, 1, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b1000, 0);
        add(0, 4'b1111, 1, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b0001, 0);
        add(0, 4'b1111, 1, 4'b0000, 0);
        // Single request for 2 (ptr=1), done releases, ptr becomes 3.
        add(0, 4'b0100, 0, 4'b0100, 0);
        add(0, 4'b1111, 0, 4'b0100, 0);  // late requests do not preempt
        add(0, 4'b0100, 1, 4'b0000, 0);
        // Wrap: ptr=3, req 0011 -> 0 then 1.
        add(0, 4'b0011, 0, 4'b0001, 0);
        add(0, 4'b0011, 1, 4'b0000, 0);
        add(0, 4'b0011, 0, 4'b0010, 0);
        add(0, 4'b0011, 1, 4'b0000, 0);
        // ptr=2: owner 2 then ptr=3, req 1001 -> 3 first.
        add(0, 4'b0100, 0, 4'b0100, 0);
        add(0, 4'b0100, 1, 4'b0000, 0);
        add(0, 4'b1001, 0, 4'b1000, 0);
        add(0, 4'b0000, 0, 4'b0000, 0);  // request drop, no timeout; ptr=0
        add(0, 4'b0000, 0, 4'b0000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].done,
                 vecs[i].exp_gnt, vecs[i].exp_tmo, $sformatf("vec%0d", i));
        end

        // Overrun: grant to 1 visible 8 cycles, then dropped with a timeout pulse.
        step(0, 4'b0010, 0, 4'b0010, 0, "tmo_grant");
        for (int k = 1; k < 8; k++) step(0, 4'b0010, 0, 4'b0010, 0, $sformatf("tmo_hold%0d", k));
        step(0, 4'b0010, 0, 4'b0000, 1, "tmo_pulse");
        step(0, 4'b0010, 0, 4'b0010, 0, "tmo_regrant");
        // Done on the limit cycle: normal release, no timeout.
        for (int k = 1; k < 8; k++) step(0, 4'b0010, 0, 4'b0010, 0, $sformatf("dl_hold%0d", k));
        step(0, 4'b0010, 1, 4'b0000, 0, "done_at_limit");
        step(0, 4'b0000, 0, 4'b0000, 0, "idle_after");

        // Reset mid-grant: ptr is 2 now, owner 1 granted, reset clears it and ptr.
        step(0, 4'b0010, 0, 4'b0010, 0, "rst_owner1");
        step(1, 4'b0010, 0, 4'b0000, 0, "rst_mid_grant");
        step(0, 4'b1111, 0, 4'b0001, 0, "rst_ptr0");
        step(0, 4'b1111, 1, 4'b0000, 0, "rst_release");
        // Request drop by owner 1 (ptr=1).
        step(0, 4'b0010, 0, 4'b0010, 0, "drop_owner1");
        step(0, 4'b0010, 0, 4'b0010, 0, "drop_hold");
        step(0, 4'b0000, 0, 4'b0000, 0, "drop_release");
        step(0, 4'b0000, 0, 4'b0000, 0, "drop_idle");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
